// File: rtl/counter_arbiter_if.sv
// counter_arbiter_if: requester handshake and shared-counter signals for counter_arbiter
interface counter_arbiter_if #(
  parameter int N = 4,
  parameter int W = 4
);
  logic [N-1:0]   req;
  logic [N*W-1:0] len;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           cnt_en;
  logic           cnt_rst;
  logic [W-1:0]   cnt_value;
  modport master (output req, len, cnt_value, input grant, done, cnt_en, cnt_rst);
  modport slave  (input req, len, cnt_value, output grant, done, cnt_en, cnt_rst);
endinterface

// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin sharing of one counter among N timed-interval requesters.
// Define COUNTER_ARBITER_ABORT_EN to let an owner cancel its operation by dropping req.
module counter_arbiter #(
  parameter int N = 4,
  parameter int W = 4
) (
  input logic               clk,
  input logic               rst,
  counter_arbiter_if.slave  bus
);
  localparam int PW = $clog2(N);
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, FIN} state_t;
  state_t        state, state_n;
  logic [PW-1:0] ptr, owner, win, k, nxt;
  logic [W-1:0]  tgt;
  logic [N-1:0]  grant_q;
  logic [W-1:0]  lens [N];
  logic          any, drop, cnt_en, cnt_rst;
  for (genvar g = 0; g < N; g++) begin : g_len
    assign lens[g] = bus.len[g*W +: W];
  end
  // walk downward so the last hit is the first set bit at or above ptr
  always_comb begin
    win = '0;
    any = 1'b0;
    k   = '0;
    for (int i = N-1; i >= 0; i--) begin
      k = PW'((int'(ptr) + i) % N);
      if (bus.req[k]) begin
        win = k;
        any = 1'b1;
      end
    end
  end
`ifdef COUNTER_ARBITER_ABORT_EN
  assign drop = (state == CLEAR || state == RUN) && !bus.req[owner];
`else
  assign drop = 1'b0;
`endif
  assign nxt = (owner == PW'(N-1)) ? '0 : owner + 1'b1;
  always_comb begin
    state_n = state;
    cnt_en  = 1'b0;
    cnt_rst = 1'b0;
    case (state)
      IDLE:  state_n = any ? CLEAR : IDLE;
      CLEAR: begin
        cnt_rst = 1'b1;
        state_n = drop ? IDLE : RUN;
      end
      RUN: begin
        cnt_en  = (bus.cnt_value != tgt) && !drop;
        state_n = drop ? IDLE : (bus.cnt_value == tgt) ? FIN : RUN;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= '0;
      tgt     <= '0;
      owner   <= '0;
      grant_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && any) begin
        tgt     <= lens[win];
        owner   <= win;
        grant_q <= N'(1) << win;
      end
      if (state == FIN || drop) begin
        grant_q <= '0;
        ptr     <= nxt;
      end
    end
  end
  assign bus.grant   = grant_q;
  assign bus.done    = (state == FIN) ? grant_q : '0;
  assign bus.cnt_en  = cnt_en;
  assign bus.cnt_rst = cnt_rst;
endmodule

// File: tb/tb_counter_arbiter.sv
// tb_counter_arbiter: directed bench with a behavioural 4-bit counter attached to the arbiter.
module tb_counter_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [15:0] len;
  logic [3:0] cnt = 4'd0;
  int n_chk = 0;
  int n_fail = 0;
  counter_arbiter_if #(.N(4), .W(4)) bus ();
  counter_arbiter #(.N(4), .W(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  assign bus.req = req;
  assign bus.len = len;
  assign bus.cnt_value = cnt;
  always #5 clk = ~clk;
  // the shared counter: synchronous clear, no connection to the arbiter reset
  always_ff @(posedge clk) begin
    if (bus.cnt_rst) cnt <= 4'd0;
    else if (bus.cnt_en) cnt <= cnt + 4'd1;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] outs();
    return {20'd0, bus.grant, bus.done, 2'b00, bus.cnt_en, bus.cnt_rst};
  endfunction
  // watches one grant from rise to fall; requester drops req on its done pulse
  task automatic run_op(input int o, input int t);
    int w, g, e, d, dat, bad;
    w = 0; g = 0; e = 0; d = 0; dat = 0; bad = 0;
    while (bus.grant == 4'd0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("grant_latency", w, 1);
    check("grant_value", bus.grant, 32'd1 << o);
    while (bus.grant != 4'd0 && g < 40) begin
      g++;
      if (bus.cnt_en) e++;
      if (bus.cnt_en && bus.cnt_rst) bad++;
      if (bus.grant != (4'd1 << o)) bad++;
      if (bus.done != 4'd0) begin
        d++;
        dat = g;
        if (bus.done != bus.grant) bad++;
        req[o] = 1'b0;
      end
      @(negedge clk);
    end
    check("grant_cycles", g, t + 3);
    check("en_cycles", e, t);
    check("done_pulses", d, 1);
    check("done_cycle", dat, t + 3);
    check("protocol", bad, 0);
    check("count_final", cnt, t);
  endtask
  initial begin
    int w, d;
    rst = 1'b0;
    req = 4'd0;
    len = 16'd0;
    repeat (2) @(negedge clk);
    check("reset_outs", outs(), 0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outs", outs(), 0);
    end
    len = 16'h0005;
    req = 4'b0001;
    run_op(0, 5);
    len = 16'h2020;
    req = 4'b1010;
    run_op(1, 2);
    req[1] = 1'b1;
    run_op(3, 2);
    run_op(1, 2);
    len = 16'h0000;
    req = 4'b0001;
    run_op(0, 0);
    len = 16'h0009;
    req = 4'b0001;
    w = 0;
    while (!(bus.grant != 4'd0 && cnt == 4'd4) && w < 30) begin
      @(negedge clk);
      w++;
    end
    check("reach_count4", cnt, 4);
    rst = 1'b0;
    #1;
    check("async_reset_outs", outs(), 0);
    check("count_held", cnt, 4);
    @(negedge clk);
    rst = 1'b1;
    run_op(0, 9);
    len = 16'h1800;
    req = 4'b0100;
    w = 0;
    while (!(bus.grant != 4'd0 && cnt == 4'd3) && w < 30) begin
      @(negedge clk);
      w++;
    end
    check("reach_count3", cnt, 3);
    req = 4'b1000;
`ifdef COUNTER_ARBITER_ABORT_EN
    #1;
    check("abort_en_low", bus.cnt_en, 0);
    check("abort_no_done", bus.done, 0);
    @(negedge clk);
    check("abort_grant_clear", bus.grant, 0);
    check("abort_done_low", bus.done, 0);
    check("abort_count", cnt, 3);
`else
    d = 0;
    w = 0;
    while (bus.grant != 4'd0 && w < 40) begin
      if (bus.done == 4'b0100) d++;
      @(negedge clk);
      w++;
    end
    check("noabort_done", d, 1);
    check("noabort_count", cnt, 8);
`endif
    run_op(3, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
